// File: rtl/spi_slave_core_if.sv
// spi_slave_core_if
//   FIFO-side handshake bundle of the SPI slave core.
//   tx_valid_i / tx_ready_o / tx_data_i : TX word offer into the holding register
//   rx_valid_o / rx_ready_i / rx_data_o : received word out of the holding register
//   modport slave  : core side
//   modport master : FIFO / peripheral side
interface spi_slave_core_if;
  localparam int unsigned SPI_DATA_WIDTH = 32;

  logic                      tx_valid_i;
  logic                      tx_ready_o;
  logic [SPI_DATA_WIDTH-1:0] tx_data_i;
  logic                      rx_valid_o;
  logic                      rx_ready_i;
  logic [SPI_DATA_WIDTH-1:0] rx_data_o;

  modport slave (
    input  tx_valid_i, tx_data_i, rx_ready_i,
    output tx_ready_o, rx_valid_o, rx_data_o
  );

  modport master (
    output tx_valid_i, tx_data_i, rx_ready_i,
    input  tx_ready_o, rx_valid_o, rx_data_o
  );
endinterface

// File: rtl/spi_slave_core.sv
// spi_slave_core
//   SPI target datapath running entirely on clk_i. SCK, CS_N and MOSI are
//   synchronised, SCK edges are detected, words of 8/16/24/32 bits are
//   deserialised into an RX holding register and serialised from a TX
//   holding register onto MISO.
// Ports
//   clk_i, rst_i        : system clock, synchronous active-high reset
//   cpol_i, cpha_i      : SPI mode, latched when a CS-low period starts
//   lsb_i, dtb_i        : bit order and word length (00=8 .. 11=32)
//   busy_o              : chip-select active (FSM out of IDLE)
//   bus (slave modport) : TX/RX valid/ready handshakes
//   ovr_o, udr_o        : sticky RX overrun / TX underrun, cleared by err_clr_i
//   spi_*               : pad-side SCK, CS_N, MOSI, MISO and MISO enable
// Configuration
//   SPI_SLAVE_ERR_FLAG_EN : when defined, ovr_o/udr_o are sticky registers;
//                           otherwise both are tied to 0.
module spi_slave_core (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cpol_i,
  input  logic                    cpha_i,
  input  logic                    lsb_i,
  input  logic [1:0]              dtb_i,
  output logic                    busy_o,
  spi_slave_core_if.slave         bus,
  output logic                    ovr_o,
  output logic                    udr_o,
  input  logic                    err_clr_i,
  input  logic                    spi_clk_i,
  input  logic                    spi_cs_n_i,
  input  logic                    spi_mosi_i,
  output logic                    spi_miso_o,
  output logic                    spi_miso_en_o
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t      state_q, state_d;
  logic [2:0]  sck_sync;
  logic [1:0]  cs_sync, mosi_sync;
  logic        armed_q;
  logic        cpol_q, cpha_q, lsb_q;
  logic [1:0]  dtb_q;
  logic [5:0]  bit_cnt;
  logic        skip_q;
  logic [31:0] tx_sr, rx_sr;
  logic [31:0] hold_data;
  logic        hold_full_q, hold_full_d, tx_ready_q;
  logic        rx_valid_q;
  logic [31:0] rx_data_q;

  logic        cs_high, sck_rise, sck_fall, lead, trail, sample_edge, shift_edge;
  logic        load_en, word_done;
  logic [1:0]  ld_dtb;
  logic        ld_lsb;
  logic [2:0]  ld_words, q_words;
  logic [5:0]  ld_bits, word_bits;
  logic [31:0] rx_aligned;
  logic        ovr_set, udr_set;

  assign cs_high = cs_sync[1];

  always_comb begin
    sck_rise    = sck_sync[1] & ~sck_sync[2];
    sck_fall    = ~sck_sync[1] & sck_sync[2];
    lead        = cpol_q ? sck_fall : sck_rise;
    trail       = cpol_q ? sck_rise : sck_fall;
    sample_edge = cpha_q ? trail : lead;
    shift_edge  = cpha_q ? lead : trail;
    // First word of a CS-low period takes its format straight from the inputs.
    ld_dtb      = (state_q == IDLE) ? dtb_i : dtb_q;
    ld_lsb      = (state_q == IDLE) ? lsb_i : lsb_q;
    ld_words    = {1'b0, ld_dtb} + 3'd1;
    ld_bits     = {ld_words, 3'b000};
    q_words     = {1'b0, dtb_q} + 3'd1;
    word_bits   = {q_words, 3'b000};
    rx_aligned  = lsb_q ? (rx_sr >> (6'd32 - word_bits)) : rx_sr;
  end

  // Next-state logic. LOAD work is done on the edge that enters LOAD so the
  // first MISO bit is already on the line while busy_o first reads 1.
  always_comb begin
    state_d   = state_q;
    word_done = 1'b0;
    unique case (state_q)
      IDLE:  if (armed_q && !cs_high) state_d = LOAD;
      LOAD:  state_d = SHIFT;
      SHIFT: if (bit_cnt == 6'd0) begin
               word_done = 1'b1;
               state_d   = LOAD;
             end
      default: state_d = IDLE;
    endcase
    if (cs_high) state_d = IDLE;
    load_en = (state_d == LOAD) && (state_q != LOAD);
  end

  always_comb begin
    hold_full_d = hold_full_q;
    if (load_en) hold_full_d = 1'b0;
    if (bus.tx_valid_i && tx_ready_q) hold_full_d = 1'b1;
  end

  assign ovr_set = word_done && rx_valid_q && !bus.rx_ready_i;
  assign udr_set = load_en && !hold_full_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      sck_sync    <= '0;
      cs_sync     <= '0;
      mosi_sync   <= '0;
      armed_q     <= 1'b0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      lsb_q       <= 1'b0;
      dtb_q       <= '0;
      bit_cnt     <= '0;
      skip_q      <= 1'b0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      hold_data   <= '0;
      hold_full_q <= 1'b0;
      tx_ready_q  <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      sck_sync    <= {sck_sync[1:0], spi_clk_i};
      cs_sync     <= {cs_sync[0], spi_cs_n_i};
      mosi_sync   <= {mosi_sync[0], spi_mosi_i};
      // After reset CS must be seen high before a new frame is accepted.
      if (cs_high) armed_q <= 1'b1;

      hold_full_q <= hold_full_d;
      tx_ready_q  <= ~hold_full_d;
      if (bus.tx_valid_i && tx_ready_q) hold_data <= bus.tx_data_i;

      if (load_en) begin
        if (state_q == IDLE) begin
          cpol_q <= cpol_i;
          cpha_q <= cpha_i;
          lsb_q  <= lsb_i;
          dtb_q  <= dtb_i;
        end
        bit_cnt <= ld_bits;
        rx_sr   <= '0;
        skip_q  <= 1'b1;
        if (hold_full_q)
          tx_sr <= ld_lsb ? hold_data : (hold_data << (6'd32 - ld_bits));
        else
          tx_sr <= '0;
      end else if (state_q == SHIFT) begin
        // A shift edge arriving before any sample edge of the word would push
        // the first bit off the line; that covers cpha=1 at frame start and
        // back-to-back words in either phase.
        if (sample_edge && bit_cnt != 6'd0) begin
          rx_sr   <= lsb_q ? {mosi_sync[1], rx_sr[31:1]} : {rx_sr[30:0], mosi_sync[1]};
          bit_cnt <= bit_cnt - 6'd1;
          skip_q  <= 1'b0;
        end else if (shift_edge) begin
          if (skip_q)
            skip_q <= 1'b0;
          else
            tx_sr <= lsb_q ? {1'b0, tx_sr[31:1]} : {tx_sr[30:0], 1'b0};
        end
      end

      if (word_done) begin
        if (!rx_valid_q || bus.rx_ready_i) begin
          rx_data_q  <= rx_aligned;
          rx_valid_q <= 1'b1;
        end
      end else if (rx_valid_q && bus.rx_ready_i) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

`ifdef SPI_SLAVE_ERR_FLAG_EN
  logic ovr_q, udr_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovr_q <= 1'b0;
      udr_q <= 1'b0;
    end else begin
      if (ovr_set)        ovr_q <= 1'b1;
      else if (err_clr_i) ovr_q <= 1'b0;
      if (udr_set)        udr_q <= 1'b1;
      else if (err_clr_i) udr_q <= 1'b0;
    end
  end
  assign ovr_o = ovr_q;
  assign udr_o = udr_q;
`else
  logic unused_flags;
  assign unused_flags = err_clr_i | ovr_set | udr_set;
  assign ovr_o = 1'b0;
  assign udr_o = 1'b0;
`endif

  assign busy_o         = (state_q != IDLE);
  assign spi_miso_en_o  = busy_o;
  assign spi_miso_o     = busy_o & (lsb_q ? tx_sr[0] : tx_sr[31]);
  assign bus.tx_ready_o = tx_ready_q;
  assign bus.rx_valid_o = rx_valid_q;
  assign bus.rx_data_o  = rx_data_q;
endmodule

// File: tb/tb_spi_slave_core.sv
module tb_spi_slave_core;
`ifdef SPI_SLAVE_ERR_FLAG_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic clk, rst, cpol, cpha, lsb, err_clr;
  logic [1:0] dtb;
  logic sck, cs_n, mosi;
  logic busy, ovr, udr, miso, miso_en;
  int n_checks = 0, n_pass = 0, n_fail = 0;
  logic [31:0] rxq[$];
  logic [31:0] mi0, mi1;

  spi_slave_core_if bus ();

  spi_slave_core dut (
    .clk_i(clk), .rst_i(rst), .cpol_i(cpol), .cpha_i(cpha), .lsb_i(lsb),
    .dtb_i(dtb), .busy_o(busy), .bus(bus), .ovr_o(ovr), .udr_o(udr),
    .err_clr_i(err_clr), .spi_clk_i(sck), .spi_cs_n_i(cs_n),
    .spi_mosi_i(mosi), .spi_miso_o(miso), .spi_miso_en_o(miso_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst && bus.rx_valid_o && bus.rx_ready_i) rxq.push_back(bus.rx_data_o);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_fall();
    sck = cpol;
    cyc(4);
    cs_n = 1'b0;
    cyc(2);
    check("cs_lat2_busy", busy, 1'b0);
    cyc(1);
    check("cs_lat3_busy", busy, 1'b1);
    check("cs_lat3_miso_en", miso_en, 1'b1);
    cyc(3);
  endtask

  task automatic cs_rise();
    cs_n = 1'b1;
    cyc(4);
    check("cs_rise_busy", busy, 1'b0);
    check("cs_rise_miso", miso, 1'b0);
    cyc(4);
  endtask

  task automatic tx_push(input logic [31:0] d);
    int n = 0;
    while (bus.tx_ready_o !== 1'b1 && n < 50) begin
      cyc(1);
      n++;
    end
    check("tx_ready_wait", bus.tx_ready_o, 1'b1);
    bus.tx_data_i  = d;
    bus.tx_valid_i = 1'b1;
    cyc(1);
    bus.tx_valid_i = 1'b0;
    check("tx_ready_fall", bus.tx_ready_o, 1'b0);
  endtask

  task automatic rx_pop();
    bus.rx_ready_i = 1'b1;
    cyc(1);
    bus.rx_ready_i = 1'b0;
    check("rx_pop_valid", bus.rx_valid_o, 1'b0);
  endtask

  task automatic half_wait(input bit lat);
    if (lat) begin
      cyc(3);
      check("rx_lat3", bus.rx_valid_o, 1'b0);
      cyc(1);
      check("rx_lat4", bus.rx_valid_o, 1'b1);
      cyc(1);
    end else cyc(5);
  endtask

  // Master side of one word: nsend of nbits bits, MISO captured into mi.
  task automatic spi_word(input int nbits, input int nsend, input logic [31:0] mo,
                          input bit lat, output logic [31:0] mi);
    int idx;
    mi = '0;
    for (int i = 0; i < nsend; i++) begin
      idx = lsb ? i : nbits - 1 - i;
      if (!cpha) begin
        mosi = mo[idx];
        cyc(5);
        mi[idx] = miso;
        sck = ~sck;
        half_wait(lat && i == nbits - 1);
        sck = ~sck;
      end else begin
        sck = ~sck;
        mosi = mo[idx];
        cyc(5);
        mi[idx] = miso;
        sck = ~sck;
        half_wait(lat && i == nbits - 1);
      end
    end
  endtask

  initial begin
    rst = 1'b1; cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; dtb = 2'b00; err_clr = 1'b0;
    sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    bus.tx_valid_i = 1'b0; bus.tx_data_i = '0; bus.rx_ready_i = 1'b0;
    cyc(3);
    check("rst_busy", busy, 1'b0);
    check("rst_tx_ready", bus.tx_ready_o, 1'b0);
    check("rst_rx_valid", bus.rx_valid_o, 1'b0);
    check("rst_rx_data", bus.rx_data_o, 32'h0);
    check("rst_ovr", ovr, 1'b0);
    check("rst_udr", udr, 1'b0);
    check("rst_miso", miso, 1'b0);
    check("rst_miso_en", miso_en, 1'b0);
    rst = 1'b0;
    cyc(4);
    check("tx_ready_idle", bus.tx_ready_o, 1'b1);

    // Mode 0, 8-bit MSB-first
    tx_push(32'h3C);
    cs_fall();
    check("m0_tx_ready_rise", bus.tx_ready_o, 1'b1);
    spi_word(8, 8, 32'hA5, 1'b1, mi0);
    cs_rise();
    check("m0_rx_valid", bus.rx_valid_o, 1'b1);
    check("m0_rx_data", bus.rx_data_o, 32'h0000_00A5);
    check("m0_miso", mi0, 32'h3C);
    rx_pop();

    // Mode 3, 32-bit LSB-first
    cpol = 1'b1; cpha = 1'b1; lsb = 1'b1; dtb = 2'b11;
    tx_push(32'h1234_5678);
    cs_fall();
    spi_word(32, 32, 32'hDEAD_BEEF, 1'b1, mi0);
    cs_rise();
    check("m3_rx_data", bus.rx_data_o, 32'hDEAD_BEEF);
    check("m3_miso", mi0, 32'h1234_5678);
    rx_pop();

    // Modes 1 and 2, 16-bit, two back-to-back words
    for (int m = 1; m <= 2; m++) begin
      cpol = (m == 2); cpha = (m == 1); lsb = 1'b0; dtb = 2'b01;
      rxq.delete();
      bus.rx_ready_i = 1'b1;
      tx_push(32'hBEEF);
      cs_fall();
      tx_push(32'hCAFE);
      spi_word(16, 16, 32'h1111, 1'b0, mi0);
      spi_word(16, 16, 32'h2222, 1'b0, mi1);
      cs_rise();
      bus.rx_ready_i = 1'b0;
      check("b2b_rx_count", rxq.size(), 2);
      check("b2b_rx_word0", rxq.size() > 0 ? rxq[0] : 32'hX, 32'h1111);
      check("b2b_rx_word1", rxq.size() > 1 ? rxq[1] : 32'hX, 32'h2222);
      check("b2b_miso0", mi0, 32'hBEEF);
      check("b2b_miso1", mi1, 32'hCAFE);
      check("b2b_tx_ready", bus.tx_ready_o, 1'b1);
      check("b2b_rx_valid_low", bus.rx_valid_o, 1'b0);
    end

    // Overrun: consumer stalled over two 8-bit words
    cpol = 1'b0; cpha = 1'b0; dtb = 2'b00;
    cs_fall();
    spi_word(8, 8, 32'h01, 1'b1, mi0);
    spi_word(8, 8, 32'h02, 1'b0, mi0);
    cs_rise();
    check("ovr_rx_data", bus.rx_data_o, 32'h01);
    check("ovr_rx_valid", bus.rx_valid_o, 1'b1);
    check("ovr_flag", ovr, FLAGS);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    check("ovr_clear", ovr, 1'b0);
    check("udr_clear", udr, 1'b0);
    rx_pop();

    // Underrun: empty TX holding register, 24-bit
    dtb = 2'b10;
    cs_fall();
    check("udr_set", udr, FLAGS);
    spi_word(24, 24, 32'h123456, 1'b1, mi0);
    cs_rise();
    check("udr_miso", mi0, 32'h0);
    check("udr_rx_data", bus.rx_data_o, 32'h0012_3456);
    rx_pop();

    // CS raised mid-word, then a full word
    dtb = 2'b00;
    cs_fall();
    spi_word(8, 5, 32'hFF, 1'b0, mi0);
    cs_rise();
    check("partial_no_valid", bus.rx_valid_o, 1'b0);
    cs_fall();
    spi_word(8, 8, 32'h5A, 1'b1, mi0);
    cs_rise();
    check("after_partial_rx", bus.rx_data_o, 32'h5A);

    // Reset mid-frame
    cs_fall();
    spi_word(8, 3, 32'hC3, 1'b0, mi0);
    rst = 1'b1;
    cyc(2);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_miso_en", miso_en, 1'b0);
    check("rstmid_miso", miso, 1'b0);
    check("rstmid_rx_valid", bus.rx_valid_o, 1'b0);
    check("rstmid_rx_data", bus.rx_data_o, 32'h0);
    check("rstmid_tx_ready", bus.tx_ready_o, 1'b0);
    check("rstmid_ovr", ovr, 1'b0);
    check("rstmid_udr", udr, 1'b0);
    rst = 1'b0;
    cyc(8);
    check("rst_ignore_cs", busy, 1'b0);
    cs_n = 1'b1;
    cyc(6);
    cs_fall();
    cs_rise();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
